mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-source (I-cache/D-cache) arbiter onto one memory request/response channel.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (source 1 wins).
module mem_bus_arbiter #(
    parameter int ADDR_W   = 28,
    parameter int LINE_W   = 128,
    parameter int MAX_OUTS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             s_req_valid,
    output logic [1:0]             s_req_ready,
    input  logic [1:0][1:0]        s_req_id,
    input  logic [1:0]             s_req_we,
    input  logic [1:0][ADDR_W-1:0] s_req_addr,
    input  logic [1:0][LINE_W-1:0] s_req_data,
    output logic [1:0]             s_resp_valid,
    input  logic [1:0]             s_resp_ready,
    output logic [1:0][1:0]        s_resp_id,
    output logic [1:0][LINE_W-1:0] s_resp_data,
    output logic                   m_req_valid,
    input  logic                   m_req_ready,
    output logic [2:0]             m_req_id,
    output logic                   m_req_we,
    output logic [ADDR_W-1:0]      m_req_addr,
    output logic [LINE_W-1:0]      m_req_data,
    input  logic                   m_resp_valid,
    output logic                   m_resp_ready,
    input  logic [2:0]             m_resp_id,
    input  logic [LINE_W-1:0]      m_resp_data,
    output logic                   err
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            lock_src_q, lock_src_d;
    logic [1:0][2:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [1:0]      elig, inc, dec;
    logic            gnt_vld, gnt_src, req_hs, resp_hs, resp_src;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic            ptr_q, ptr_d;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_src = 1'b0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = s_req_valid[i] && (cnt_q[i] != 3'(MAX_OUTS));
        end
        if (state_q == LOCK) begin
            gnt_vld = 1'b1;
            gnt_src = lock_src_q;
        end else if (elig == 2'b11) begin
            gnt_vld = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gnt_src = ptr_q;
`else
            gnt_src = 1'b1;
`endif
        end else if (elig[1]) begin
            gnt_vld = 1'b1;
            gnt_src = 1'b1;
        end else if (elig[0]) begin
            gnt_vld = 1'b1;
        end
        // Everything visible is gated by reset so outputs drop immediately.
        gnt_vld = gnt_vld && rst;
    end

    always_comb begin
        m_req_valid  = gnt_vld && s_req_valid[gnt_src];
        m_req_id     = gnt_vld ? {gnt_src, s_req_id[gnt_src]} : 3'd0;
        m_req_we     = gnt_vld && s_req_we[gnt_src];
        m_req_addr   = gnt_vld ? s_req_addr[gnt_src] : '0;
        m_req_data   = gnt_vld ? s_req_data[gnt_src] : '0;
        s_req_ready  = 2'b00;
        if (gnt_vld) begin
            s_req_ready[gnt_src] = m_req_ready;
        end
        resp_src     = m_resp_id[2];
        m_resp_ready = rst && s_resp_ready[resp_src];
        s_resp_valid = 2'b00;
        s_resp_valid[resp_src] = rst && m_resp_valid;
        for (int i = 0; i < 2; i++) begin
            s_resp_id[i]   = m_resp_id[1:0];
            s_resp_data[i] = m_resp_data;
        end
        req_hs  = m_req_valid && m_req_ready;
        resp_hs = m_resp_valid && m_resp_ready;
        inc = 2'b00;
        dec = 2'b00;
        inc[gnt_src]  = req_hs;
        dec[resp_src] = resp_hs;
    end

    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
        if (req_hs) begin
            ptr_d = ~gnt_src;
        end
`endif
        case (state_q)
            IDLE: if (gnt_vld && !m_req_ready) begin
                state_d    = LOCK;
                lock_src_d = gnt_src;
            end
            LOCK: if (req_hs) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A response to a source with nothing outstanding is flagged but still delivered.
        for (int i = 0; i < 2; i++) begin
            if (dec[i] && cnt_q[i] == 3'd0) begin
                err_d = 1'b1;
            end
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end else if (dec[i] && !inc[i] && cnt_q[i] != 3'd0) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lock_src_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int ADDR_W   = 28;
    localparam int LINE_W   = 128;
    localparam int MAX_OUTS = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]             s_req_valid, s_req_ready, s_req_we, s_resp_valid, s_resp_ready;
    logic [1:0][1:0]        s_req_id, s_resp_id;
    logic [1:0][ADDR_W-1:0] s_req_addr;
    logic [1:0][LINE_W-1:0] s_req_data, s_resp_data;
    logic                   m_req_valid, m_req_ready, m_req_we, m_resp_valid, m_resp_ready, err;
    logic [2:0]             m_req_id, m_resp_id;
    logic [ADDR_W-1:0]      m_req_addr;
    logic [LINE_W-1:0]      m_req_data, m_resp_data;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_id(s_req_id),
        .s_req_we(s_req_we), .s_req_addr(s_req_addr), .s_req_data(s_req_data),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_id(s_resp_id),
        .s_resp_data(s_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_id(m_req_id),
        .m_req_we(m_req_we), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_id(m_resp_id),
        .m_resp_data(m_resp_data), .err(err)
    );

    typedef struct packed {
        logic              mv;
        logic [2:0]        mid;
        logic              mwe;
        logic [ADDR_W-1:0] maddr;
        logic [LINE_W-1:0] mdata;
        logic [1:0]        srdy;
        logic              mrr;
        logic [1:0]        srv;
        int                src;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int pend   = -1;   // source holding the bus while memory stalls, -1 if none
    int turn   = 0;    // source favoured on a tie
    int outs[2];
    bit m_err  = 1'b0;
    bit hs_prev[2];
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_comb();
        exp_t e;
        int   src;
        bit   ok0, ok1;
        e = '0;
        e.src = -1;
        src = -1;
        if (!rst) return e;
        if (pend >= 0) begin
            src = pend;
        end else begin
            ok0 = s_req_valid[0] && (outs[0] < MAX_OUTS);
            ok1 = s_req_valid[1] && (outs[1] < MAX_OUTS);
            if (ok0 && ok1) src = RR ? turn : 1;
            else if (ok1)   src = 1;
            else if (ok0)   src = 0;
        end
        if (src >= 0) begin
            e.src   = src;
            e.mv    = s_req_valid[src];
            e.mid   = {src[0], s_req_id[src]};
            e.mwe   = s_req_we[src];
            e.maddr = s_req_addr[src];
            e.mdata = s_req_data[src];
            e.srdy[src] = m_req_ready;
        end
        e.mrr = s_resp_ready[m_resp_id[2]];
        e.srv[m_resp_id[2]] = m_resp_valid;
        return e;
    endfunction

    task automatic model_update();
        exp_t e;
        bit   rq, rs;
        int   rsrc;
        int   nxt[2];
        hs_prev[0] = 1'b0;
        hs_prev[1] = 1'b0;
        if (!rst) begin
            pend = -1; turn = 0; outs[0] = 0; outs[1] = 0; m_err = 1'b0;
            return;
        end
        e    = model_comb();
        rq   = e.mv && m_req_ready;
        rs   = m_resp_valid && e.mrr;
        rsrc = int'(m_resp_id[2]);
        if (pend < 0 && e.src >= 0 && !m_req_ready) pend = e.src;
        else if (pend >= 0 && rq)                    pend = -1;
        nxt[0] = outs[0];
        nxt[1] = outs[1];
        if (rs && outs[rsrc] == 0) m_err = 1'b1;
        if (rq) begin
            hs_prev[e.src] = 1'b1;
            turn = 1 - e.src;
            nxt[e.src]++;
        end
        if (rs && (outs[rsrc] > 0 || (rq && e.src == rsrc))) nxt[rsrc]--;
        outs[0] = nxt[0];
        outs[1] = nxt[1];
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (chk_en) begin
            e = model_comb();
            chk("m_req_valid",  128'(m_req_valid),  128'(e.mv));
            chk("m_req_id",     128'(m_req_id),     128'(e.mid));
            chk("m_req_we",     128'(m_req_we),     128'(e.mwe));
            chk("m_req_addr",   128'(m_req_addr),   128'(e.maddr));
            chk("m_req_data",   128'(m_req_data),   128'(e.mdata));
            chk("s_req_ready",  128'(s_req_ready),  128'(e.srdy));
            chk("m_resp_ready", 128'(m_resp_ready), 128'(e.mrr));
            chk("s_resp_valid", 128'(s_resp_valid), 128'(e.srv));
            chk("err",          128'(err),          128'(rst ? m_err : 1'b0));
            for (int i = 0; i < 2; i++) begin
                if (e.srv[i]) begin
                    chk("s_resp_id",   128'(s_resp_id[i]), 128'(m_resp_id[1:0]));
                    chk("s_resp_data", s_resp_data[i],     m_resp_data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        s_req_valid = '0; s_req_id = '0; s_req_we = '0; s_req_addr = '0; s_req_data = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_id = '0; m_resp_data = '0;
        s_resp_ready = '0;
    endtask

    task automatic drain();
        idle();
        for (int s = 0; s < 2; s++) begin
            while (outs[s] > 0) begin
                m_resp_valid = 1'b1;
                m_resp_id    = {s[0], 2'b01};
                m_resp_data  = {4{$urandom}};
                s_resp_ready = 2'b11;
                cyc();
            end
        end
        idle();
    endtask

    initial begin
        idle();
        chk_en = 1'b1;
        cyc();
        // Reset holds every valid/ready output low even with all inputs active.
        s_req_valid = 2'b11; m_req_ready = 1'b1; m_resp_valid = 1'b1; s_resp_ready = 2'b11;
        #1;
        chk("rst_m_req_valid",  128'(m_req_valid),  128'(0));
        chk("rst_s_req_ready",  128'(s_req_ready),  128'(0));
        chk("rst_s_resp_valid", 128'(s_resp_valid), 128'(0));
        chk("rst_m_resp_ready", 128'(m_resp_ready), 128'(0));
        chk("rst_err",          128'(err),          128'(0));
        cyc();
        idle();
        rst = 1'b1;
        cyc();

        // Both sources contending with memory always ready.
        s_req_valid = 2'b11; m_req_ready = 1'b1;
        s_req_addr[0] = 28'h0AAAAAA; s_req_addr[1] = 28'h0BBBBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_grant_src", 128'(m_req_id[2]), 128'(RR ? (k % 2) : 1));
            chk("alt_s_req_ready", 128'(s_req_ready), 128'(RR ? ((k % 2) ? 2 : 1) : 2));
            cyc();
        end
        drain();

        // Memory stall locks source 0 even after source 1 appears.
        s_req_valid = 2'b01; s_req_addr[0] = 28'h0000123; s_req_id[0] = 2'd3;
        s_req_addr[1] = 28'h0000456; s_req_id[1] = 2'd1;
        #1;
        chk("lock_c1_addr", 128'(m_req_addr), 128'(28'h0000123));
        chk("lock_c1_id",   128'(m_req_id),   128'(3'b011));
        cyc();
        s_req_valid = 2'b11;
        #1;
        chk("lock_c2_addr", 128'(m_req_addr),  128'(28'h0000123));
        chk("lock_c2_rdy",  128'(s_req_ready), 128'(2'b00));
        cyc();
        #1;
        chk("lock_c3_addr", 128'(m_req_addr), 128'(28'h0000123));
        cyc();
        m_req_ready = 1'b1;
        #1;
        chk("lock_c4_rdy", 128'(s_req_ready), 128'(2'b01));
        chk("lock_c4_id",  128'(m_req_id),    128'(3'b011));
        cyc();
        s_req_valid = 2'b10;
        #1;
        chk("lock_c5_id",   128'(m_req_id),    128'(3'b101));
        chk("lock_c5_addr", 128'(m_req_addr),  128'(28'h0000456));
        chk("lock_c5_rdy",  128'(s_req_ready), 128'(2'b10));
        cyc();
        drain();

        // Outstanding limit on source 1.
        s_req_valid = 2'b10; m_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("outs_accept", 128'(s_req_ready[1]), 128'(1));
            cyc();
        end
        #1;
        chk("outs_stall_rdy", 128'(s_req_ready), 128'(2'b00));
        chk("outs_stall_vld", 128'(m_req_valid), 128'(0));
        m_resp_valid = 1'b1; m_resp_id = 3'b101; s_resp_ready = 2'b10;
        #1;
        chk("outs_resp_rdy",   128'(m_resp_ready), 128'(1));
        chk("outs_resp_vld",   128'(s_resp_valid), 128'(2'b10));
        chk("outs_still_stall", 128'(s_req_ready), 128'(2'b00));
        cyc();
        m_resp_valid = 1'b0;
        #1;
        chk("outs_release", 128'(s_req_ready), 128'(2'b10));
        cyc();
        drain();

        // Response back-pressure and routing to source 0.
        s_req_valid = 2'b01; m_req_ready = 1'b1;
        cyc();
        idle();
        m_resp_valid = 1'b1; m_resp_id = 3'b010; s_resp_ready = 2'b00;
        m_resp_data = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D;
        #1;
        chk("resp_bp_rdy", 128'(m_resp_ready), 128'(0));
        chk("resp_bp_vld", 128'(s_resp_valid), 128'(2'b01));
        cyc();
        s_resp_ready = 2'b01;
        #1;
        chk("resp_rdy",  128'(m_resp_ready),   128'(1));
        chk("resp_id",   128'(s_resp_id[0]),   128'(2'b10));
        chk("resp_data", s_resp_data[0],       128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D);
        cyc();
        idle();
        #1;
        chk("no_err_yet", 128'(err), 128'(0));

        // Stray response raises a sticky error; counter must stay at zero.
        m_resp_valid = 1'b1; m_resp_id = 3'b000; s_resp_ready = 2'b01;
        #1;
        chk("stray_delivered", 128'(s_resp_valid), 128'(2'b01));
        cyc();
        idle();
        #1;
        chk("err_set", 128'(err), 128'(1));
        cyc();
        s_req_valid = 2'b01; m_req_ready = 1'b1;
        #1;
        chk("err_sticky", 128'(err), 128'(1));
        for (int k = 0; k < 4; k++) cyc();
        #1;
        chk("cnt_held_zero", 128'(s_req_ready), 128'(2'b00));
        drain();

        // Reset while locked abandons the grant.
        s_req_valid = 2'b01; m_req_ready = 1'b0;
        cyc();
        rst = 1'b0; m_resp_valid = 1'b1; s_resp_ready = 2'b11;
        #1;
        chk("midrst_m_valid", 128'(m_req_valid),  128'(0));
        chk("midrst_s_rdy",   128'(s_req_ready),  128'(0));
        chk("midrst_resp",    128'(s_resp_valid), 128'(0));
        chk("midrst_err",     128'(err),          128'(0));
        cyc();
        rst = 1'b1; s_req_valid = 2'b10; m_resp_valid = 1'b0;
        #1;
        chk("fresh_grant", 128'(m_req_id[2]), 128'(1));
        chk("fresh_valid", 128'(m_req_valid), 128'(1));
        m_req_ready = 1'b1;
        cyc();
        drain();

        // Randomized traffic with sources holding requests until accepted.
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (!s_req_valid[s] || hs_prev[s]) begin
                    s_req_valid[s] = ($urandom % 3) != 0;
                    s_req_id[s]    = 2'($urandom);
                    s_req_we[s]    = 1'($urandom);
                    s_req_addr[s]  = ADDR_W'($urandom);
                    s_req_data[s]  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            m_req_ready = 1'($urandom);
            begin
                int rs;
                rs = int'($urandom % 2);
                if (outs[rs] > 0 && ($urandom % 2) == 0) begin
                    m_resp_valid = 1'b1;
                    m_resp_id    = {rs[0], 2'($urandom)};
                    m_resp_data  = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    m_resp_valid = 1'b0;
                end
            end
            s_resp_ready = 2'($urandom);
            rst = (n % 700 == 350) ? 1'b0 : 1'b1;
            cyc();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
